// File: rtl/package_settings.sv
// package_settings: shared datapath sizing for the filter chain.
// SIZE_FILTER_DATA is the MSB index of a signed filter sample.
package package_settings;
    localparam int SIZE_FILTER_DATA = 15;
endpackage

// File: rtl/peak_detector_pkg.sv
// peak_detector_pkg: detector FSM states and the event record.
// peak_event_t is laid out for the default configuration (TS_WIDTH=32, MAX_LEN=64).
// The top derives an equivalent record sized to its own parameters.
package peak_detector_pkg;
    import package_settings::*;
    typedef enum logic [1:0] {IDLE, PEAK, HOLDOFF} peak_state_t;
    typedef struct packed {
        logic signed [SIZE_FILTER_DATA:0] amp;
        logic [31:0]                      ts;
        logic [6:0]                       width;
        logic                             trunc;
    } peak_event_t;
endpackage

// File: rtl/filter_peak_detector_slot.sv
// peak_event_slot: 1-deep valid/ready holding register for detector events.
// Ports: clk, reset (async active-low), load (event offered), d (event),
//        valid/ready (consumer handshake), q (held event),
//        lost_count (saturating count of events offered while the slot was full).
module peak_event_slot
    import peak_detector_pkg::*;
#(
    parameter type T = peak_event_t
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  T            d,
    output logic        valid,
    input  logic        ready,
    output T            q,
    output logic [15:0] lost_count
);
    // A full slot can still take a new event on the cycle it is being drained.
    logic accept;
    assign accept = !valid || ready;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            valid      <= 1'b0;
            q          <= '0;
            lost_count <= '0;
        end else begin
            if (load && accept) begin
                valid <= 1'b1;
                q     <= d;
            end else if (valid && ready)
                valid <= 1'b0;
            if (load && !accept && lost_count != 16'hFFFF)
                lost_count <= lost_count + 16'd1;
        end
endmodule

// File: rtl/filter_peak_detector.sv
// filter_peak_detector: finds pulses in the shaped filter stream and reports
// amplitude, time of maximum and width of each one.
// Ports: clk, reset (async active-low), enable, filter_data (signed sample every cycle),
//        peak_valid/peak_ready (event handshake), peak_amp, peak_time, peak_width,
//        peak_trunc (pulse reached MAX_LEN), lost_count (events dropped on a full slot).
module filter_peak_detector
    import package_settings::*;
    import peak_detector_pkg::*;
#(
    parameter int THRESHOLD = 64,
    parameter int HOLDOFF   = 16,
    parameter int MAX_LEN   = 64,
    parameter int TS_WIDTH  = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic signed [SIZE_FILTER_DATA:0]     filter_data,
    output logic                                 peak_valid,
    input  logic                                 peak_ready,
    output logic signed [SIZE_FILTER_DATA:0]     peak_amp,
    output logic [TS_WIDTH-1:0]                  peak_time,
    output logic [$clog2(MAX_LEN+1)-1:0]         peak_width,
    output logic                                 peak_trunc,
    output logic [15:0]                          lost_count
);
    localparam int WW = $clog2(MAX_LEN+1);
    localparam int HW = $clog2(HOLDOFF+1);
    localparam logic signed [SIZE_FILTER_DATA:0] THR = (SIZE_FILTER_DATA+1)'(THRESHOLD);
    localparam logic [WW-1:0] ML = WW'(MAX_LEN);
    localparam logic [HW-1:0] HO = HW'(HOLDOFF);
    typedef struct packed {
        logic signed [SIZE_FILTER_DATA:0] amp;
        logic [TS_WIDTH-1:0]              ts;
        logic [WW-1:0]                    width;
        logic                             trunc;
    } ev_t;
    logic [TS_WIDTH-1:0]              ts_cnt, ts_q, tm, tm_d;
    logic signed [SIZE_FILTER_DATA:0] sample_q, amp, amp_d;
    logic [WW-1:0]                    width, width_d;
    logic [HW-1:0]                    hcnt, hcnt_d;
    peak_state_t                      state, state_d;
    logic                             above, emit, trunc;
    ev_t                              ev_d, ev_q;
    assign above = sample_q > THR;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            ts_cnt   <= '0;
            ts_q     <= '0;
            sample_q <= '0;
            state    <= IDLE;
            amp      <= '0;
            tm       <= '0;
            width    <= '0;
            hcnt     <= '0;
        end else begin
            ts_cnt   <= ts_cnt + 1'b1;
            ts_q     <= ts_cnt;
            sample_q <= filter_data;
            state    <= state_d;
            amp      <= amp_d;
            tm       <= tm_d;
            width    <= width_d;
            hcnt     <= hcnt_d;
        end
    // The emitted event is built from the *_d values so that a final sample
    // which is also the new maximum is reflected in the event.
    always_comb begin
        state_d = state;
        amp_d   = amp;
        tm_d    = tm;
        width_d = width;
        hcnt_d  = hcnt;
        emit    = 1'b0;
        trunc   = 1'b0;
        if (!enable)
            state_d = IDLE;
        else
            case (state)
                IDLE:
                    if (above) begin
                        state_d = PEAK;
                        amp_d   = sample_q;
                        tm_d    = ts_q;
                        width_d = WW'(1);
                    end
                PEAK:
                    if (above) begin
                        width_d = width + 1'b1;
                        if (sample_q > amp) begin
                            amp_d = sample_q;
                            tm_d  = ts_q;
                        end
                        if (width_d == ML) begin
                            emit    = 1'b1;
                            trunc   = 1'b1;
                            hcnt_d  = '0;
                            state_d = peak_detector_pkg::HOLDOFF;
                        end
                    end else begin
                        // the terminating sample is already the first quiet sample
                        emit    = 1'b1;
                        hcnt_d  = HW'(1);
                        state_d = (HO <= HW'(1)) ? IDLE : peak_detector_pkg::HOLDOFF;
                    end
                default: begin
                    hcnt_d = above ? '0 : hcnt + 1'b1;
                    if (hcnt_d == HO)
                        state_d = IDLE;
                end
            endcase
    end
    assign ev_d = '{amp: amp_d, ts: tm_d, width: width_d, trunc: trunc};
    peak_event_slot #(.T(ev_t)) u_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (emit),
        .d          (ev_d),
        .valid      (peak_valid),
        .ready      (peak_ready),
        .q          (ev_q),
        .lost_count (lost_count)
    );
    assign peak_amp   = ev_q.amp;
    assign peak_time  = ev_q.ts;
    assign peak_width = ev_q.width;
    assign peak_trunc = ev_q.trunc;
endmodule
